// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : display_arbiter
// Description : Chooses what the 4-digit 7-segment scanner shows: current
//               time, alarm time, time with a blinking digit pair while the
//               user sets it, or the whole display flashing while the alarm
//               rings. Also generates the scanner refresh tick.
//
// Ports
//   clk          in   1   system clock, all state on rising edge
//   reset        in   1   asynchronous, active-high reset
//   time_seg     in  32   current-time segment codes (active-low, bit7 = dp)
//                         [7:0] ones-min, [15:8] tens-min,
//                         [23:16] ones-hour, [31:24] tens-hour
//   alarm_seg    in  32   alarm-time segment codes, same packing
//   alarm_req    in   1   level request to view the alarm time
//   set_mode     in   2   00 normal, 01 set minutes, 10 set hours, 11 = 00
//   ringing      in   1   alarm sounding (level)
//   refresh_tick out  1   one-clk pulse advancing the digit scanner
//   digit_seg    out 32   registered segment codes for the scanner
//   view         out  2   active source: 00 TIME, 01 ALARM, 10 SET, 11 RING
//
// Revision    : 1.0 - initial release
// ============================================================================
module display_arbiter #(
    parameter int REFRESH_DIV = 100000,  // clk cycles per refresh tick
    parameter int BLINK_DIV   = 250      // refresh ticks per blink half-period
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] time_seg,
    input  logic [31:0] alarm_seg,
    input  logic        alarm_req,
    input  logic [1:0]  set_mode,
    input  logic        ringing,
    output logic        refresh_tick,
    output logic [31:0] digit_seg,
    output logic [1:0]  view
);

    localparam int c_PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(REFRESH_DIV - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_MAX = c_BLK_W'(BLINK_DIV - 1);

    // State encoding doubles as the view output code.
    localparam logic [1:0] c_ST_TIME  = 2'b00;
    localparam logic [1:0] c_ST_ALARM = 2'b01;
    localparam logic [1:0] c_ST_SET   = 2'b10;
    localparam logic [1:0] c_ST_RING  = 2'b11;

    logic [c_PRE_W-1:0] pre_q;
    logic               tick_q;
    logic [1:0]         frame_q;
    logic [c_BLK_W-1:0] blink_cnt_q;
    logic               blink_phase_q;
    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [31:0]        seg_q;
    logic [31:0]        seg_d;

    logic               w_wrap;
    logic               w_frame_end;
    logic               w_state_chg;
    logic [1:0]         w_target;

    // The tick is registered, so it is high in the cycle the prescaler
    // reads 0 after wrapping. Frame counter and blink counter advance on the
    // same edge, so the fourth tick of a frame is also the state-change edge.
    assign w_wrap      = (pre_q == c_PRE_MAX);
    assign w_frame_end = w_wrap && (frame_q == 2'd3);
    assign w_state_chg = w_frame_end && (state_d != state_q);

    // ------------------------------------------------------------------
    // Prescaler, frame counter, blink counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q         <= '0;
            tick_q        <= 1'b0;
            frame_q       <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            pre_q  <= w_wrap ? '0 : pre_q + c_PRE_W'(1);
            tick_q <= w_wrap;
            if (w_wrap) begin
                frame_q <= frame_q + 2'd1;
            end
            // A new view always starts with its digits visible.
            if (w_state_chg) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= 1'b0;
            end else if (w_wrap) begin
                if (blink_cnt_q == c_BLK_MAX) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + c_BLK_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= c_ST_TIME;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Requests are sampled only on frame_end, so a
    // request that comes and goes within one frame is never seen.
    // ------------------------------------------------------------------
    always_comb begin
        w_target = c_ST_TIME;
        if (ringing) begin
            w_target = c_ST_RING;
        end else if ((set_mode == 2'b01) || (set_mode == 2'b10)) begin
            w_target = c_ST_SET;
        end else if (alarm_req) begin
            w_target = c_ST_ALARM;
        end

        state_d = state_q;
        if (w_frame_end) begin
            state_d = w_target;
        end
    end

    // ------------------------------------------------------------------
    // FSM: output selection. set_mode is used live inside SET so that
    // switching minutes/hours moves the blanked pair on the next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        seg_d = time_seg;
        case (state_q)
            c_ST_TIME: begin
                seg_d = time_seg;
            end
            c_ST_ALARM: begin
                seg_d = alarm_seg;
            end
            c_ST_SET: begin
                if (blink_phase_q) begin
                    if (set_mode == 2'b01) begin
                        seg_d[15:0] = 16'hFFFF;
                    end else if (set_mode == 2'b10) begin
                        seg_d[31:16] = 16'hFFFF;
                    end
                end
            end
            default: begin
                if (blink_phase_q) begin
                    seg_d = 32'hFFFF_FFFF;
                end
            end
        endcase
    end

    // Registered segment output; all-off during reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= 32'hFFFF_FFFF;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign refresh_tick = tick_q;
    assign digit_seg    = seg_q;
    assign view         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_arbiter
// Description : Self-checking bench for display_arbiter (REFRESH_DIV=4,
//               BLINK_DIV=2). A cycle-level model derived from tick/frame
//               arithmetic is compared against the DUT every cycle, and
//               directed scenarios pin hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_arbiter;

    localparam int RD = 4;
    localparam int BD = 2;

    localparam logic [31:0] T1 = 32'hC0F9_A4B0;
    localparam logic [31:0] T2 = 32'h9992_8280;
    localparam logic [31:0] A1 = 32'hF8C0_A499;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] time_seg = T1;
    logic [31:0] alarm_seg = A1;
    logic        alarm_req = 1'b0;
    logic [1:0]  set_mode = 2'b00;
    logic        ringing = 1'b0;
    logic        refresh_tick;
    logic [31:0] digit_seg;
    logic [1:0]  view;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    display_arbiter #(
        .REFRESH_DIV(RD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .time_seg    (time_seg),
        .alarm_seg   (alarm_seg),
        .alarm_req   (alarm_req),
        .set_mode    (set_mode),
        .ringing     (ringing),
        .refresh_tick(refresh_tick),
        .digit_seg   (digit_seg),
        .view        (view)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: time measured in clks since reset release (m_n).
    // Ticks fall on multiples of RD, frame ends on multiples of 4*RD.
    // Blink phase = (ticks since entering the view / BD) mod 2.
    // ------------------------------------------------------------------
    int          m_n = 0;
    int          m_ticks = 0;
    logic [1:0]  m_state = 2'd0;
    logic        m_tick = 1'b0;
    logic [31:0] m_seg = 32'hFFFF_FFFF;

    function automatic logic [1:0] tgt(input logic r, input logic [1:0] sm, input logic a);
        if (r) return 2'd3;
        if (sm == 2'b01 || sm == 2'b10) return 2'd2;
        if (a) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] exp_seg(input logic [1:0] st, input bit ph,
                                            input logic [31:0] t, input logic [31:0] a,
                                            input logic [1:0] sm);
        case (st)
            2'd0: return t;
            2'd1: return a;
            2'd2: begin
                if (ph && sm == 2'b01) return {t[31:16], 16'hFFFF};
                if (ph && sm == 2'b10) return {16'hFFFF, t[15:0]};
                return t;
            end
            default: return ph ? 32'hFFFF_FFFF : t;
        endcase
    endfunction

    initial begin
        logic [1:0] nt;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_n     = 0;
                m_ticks = 0;
                m_state = 2'd0;
                m_tick  = 1'b0;
                m_seg   = 32'hFFFF_FFFF;
            end else begin
                m_seg  = exp_seg(m_state, ((m_ticks / BD) % 2) == 1, time_seg, alarm_seg, set_mode);
                m_n++;
                m_tick = (m_n % RD) == 0;
                if (m_tick) begin
                    nt = tgt(ringing, set_mode, alarm_req);
                    if ((m_n % (4 * RD)) == 0 && nt != m_state) begin
                        m_state = nt;
                        m_ticks = 0;
                    end else begin
                        m_ticks++;
                    end
                end
            end
        end
    end

    // Per-cycle compare on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model_tick", {31'd0, refresh_tick}, {31'd0, m_tick});
                check("model_view", {30'd0, view}, {30'd0, m_state});
                check("model_seg", digit_seg, m_seg);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_seg", digit_seg, 32'hFFFF_FFFF);
        check("rst_view", {30'd0, view}, 32'd0);
        check("rst_tick", {31'd0, refresh_tick}, 32'd0);
        step();

        // Release; the next rising edge is clk 1.
        reset = 1'b0;
        cyc   = 0;
        goto(1);  check("seg_after_release", digit_seg, T1);
        goto(3);  check("no_tick_clk3", {31'd0, refresh_tick}, 32'd0);
        goto(4);  check("tick_clk4", {31'd0, refresh_tick}, 32'd1);
        alarm_req = 1'b1;
        goto(5);  check("no_tick_clk5", {31'd0, refresh_tick}, 32'd0);
        goto(8);  check("tick_clk8", {31'd0, refresh_tick}, 32'd1);
        goto(15); check("alarm_wait_view", {30'd0, view}, 32'd0);
        goto(16); check("alarm_view", {30'd0, view}, 32'd1);
        goto(17); check("alarm_seg", digit_seg, A1);
        alarm_req = 1'b0;
        goto(31); check("alarm_hold_view", {30'd0, view}, 32'd1);
        goto(32); check("alarm_exit_view", {30'd0, view}, 32'd0);
        goto(33); check("time_back_seg", digit_seg, T1);

        // Short request inside one frame must be ignored.
        goto(36); alarm_req = 1'b1;
        goto(41); alarm_req = 1'b0;
        goto(48); check("pulse_ignored_view", {30'd0, view}, 32'd0);
        goto(49); check("pulse_ignored_seg", digit_seg, T1);

        // Setting hours, then switching to minutes mid-blink.
        set_mode = 2'b10;
        goto(64); check("set_view", {30'd0, view}, 32'd2);
        goto(65); check("set_visible_first", digit_seg, T1);
        goto(72); check("set_still_visible", digit_seg, T1);
        goto(73); check("set_hours_blank", digit_seg, {16'hFFFF, T1[15:0]});
        set_mode = 2'b01;
        goto(74); check("set_min_blank", digit_seg, {T1[31:16], 16'hFFFF});
        check("set_switch_view", {30'd0, view}, 32'd2);
        goto(80); check("set_min_blank_hold", digit_seg, {T1[31:16], 16'hFFFF});
        goto(81); check("set_min_visible", digit_seg, T1);

        // Ringing wins over set_mode and alarm_req.
        ringing   = 1'b1;
        alarm_req = 1'b1;
        goto(95); check("ring_wait_view", {30'd0, view}, 32'd2);
        goto(96); check("ring_view", {30'd0, view}, 32'd3);
        goto(97); check("ring_visible_first", digit_seg, T1);
        time_seg = T2;
        goto(98); check("ring_data_pass", digit_seg, T2);
        goto(104); check("ring_still_visible", digit_seg, T2);
        goto(105); check("ring_all_off", digit_seg, 32'hFFFF_FFFF);
        goto(112); check("ring_all_off_hold", digit_seg, 32'hFFFF_FFFF);
        goto(113); check("ring_visible_again", digit_seg, T2);

        // Reset mid-frame and mid-blink while ringing.
        goto(114);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_seg", digit_seg, 32'hFFFF_FFFF);
        check("midrst_view", {30'd0, view}, 32'd0);
        check("midrst_tick", {31'd0, refresh_tick}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        goto(1);  check("rel2_seg", digit_seg, T2);
        goto(3);  check("rel2_no_tick", {31'd0, refresh_tick}, 32'd0);
        goto(4);  check("rel2_tick", {31'd0, refresh_tick}, 32'd1);
        goto(15); check("rel2_no_pending", {30'd0, view}, 32'd0);
        goto(16); check("rel2_ring_view", {30'd0, view}, 32'd3);
        goto(17); check("rel2_ring_visible", digit_seg, T2);
        goto(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameters SHALL be: REFRESH_DIV, 100000, clk cycles per refresh tick (1 kHz at 100 MHz); BLINK_DIV, 250, refresh ticks per blink half-period.
REQ-002 Port: clk  in  1  system clock; one clock only, all state on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: time_seg  in  32  current-time segment codes; [7:0] ones-min, [15:8] tens-min, [23:16] ones-hour, [31:24] tens-hour; active-low, bit 7 = dp.
REQ-005 Port: alarm_seg  in  32  alarm-time segment codes, same packing.
REQ-006 Port: alarm_req  in  1  level request to view the alarm time.
REQ-007 Port: set_mode  in  2  00 normal, 01 setting minutes, 10 setting hours, 11 treated as 00.
REQ-008 Port: ringing  in  1  alarm sounding; level.
REQ-009 Port: refresh_tick  out  1  one-clk pulse that advances the digit scanner.
REQ-010 Port: digit_seg  out  32  segment codes for the scanner, same packing as time_seg.
REQ-011 Port: view  out  2  active source: 00 TIME, 01 ALARM, 10 SET, 11 RING.

Function
REQ-012 Prescaler SHALL count 0..REFRESH_DIV-1; refresh_tick SHALL be 1 for exactly the cycle the count wraps to 0, and 0 otherwise.
REQ-013 A 2-bit frame counter SHALL increment on every refresh_tick; frame_end SHALL be a refresh_tick with frame counter = 3.
REQ-014 The FSM SHALL have four states TIME, ALARM, SET, RING; view SHALL equal the state encoding in REQ-011.
REQ-015 Target state priority: ringing -> RING; else set_mode 01/10 -> SET; else alarm_req -> ALARM; else TIME.
REQ-016 State changes SHALL occur only on frame_end (no mid-frame tearing); a request that rises and falls between two frame_ends SHALL be ignored.
REQ-017 Blink counter SHALL count refresh ticks 0..BLINK_DIV-1; blink_phase SHALL toggle on wrap.
REQ-018 On any state transition, the blink counter and blink_phase SHALL clear to 0 (digits visible first).
REQ-019 digit_seg SHALL be registered, reflecting state and inputs of the previous cycle (1-clk latency).
REQ-020 TIME: digit_seg = time_seg. ALARM: digit_seg = alarm_seg.
REQ-021 SET/01: time_seg with bytes [15:0] forced to 8'hFF when blink_phase = 1; SET/10: bytes [31:16] forced likewise.
REQ-022 In SET, a change between 01 and 10 SHALL switch the blanked pair on the next cycle without a state change or blink reset.
REQ-023 RING: digit_seg = time_seg when blink_phase = 0, 32'hFFFF_FFFF when blink_phase = 1.
REQ-024 Input data changes (time_seg/alarm_seg) SHALL pass through at any cycle, independent of frame_end.

Reset
REQ-025 Asserting reset SHALL immediately clear prescaler, frame counter, blink counter and blink_phase to 0, state to TIME, refresh_tick to 0, view to 00, digit_seg to 32'hFFFF_FFFF.
REQ-026 After reset deassertion, the first refresh_tick SHALL occur REFRESH_DIV clks later; digit_seg SHALL show time_seg from the first clk after deassertion.
REQ-027 Reset asserted mid-frame or mid-blink SHALL discard all in-progress counts; no pending transition survives reset.

Verification (REFRESH_DIV=4, BLINK_DIV=2)
REQ-028 Reset release, idle inputs -> refresh_tick on clks 4, 8, 12...; view=00; digit_seg=time_seg after 1 clk.
REQ-029 alarm_req=1 at clk 5 -> view=01 at frame_end clk 16, digit_seg=alarm_seg next clk; alarm_req=0 -> view=00 at next frame_end.
REQ-030 alarm_req pulse clks 5-9 only -> view stays 00 throughout.
REQ-031 set_mode=10 in SET -> bytes [31:16] alternate time_seg / 8'hFF every 2 ticks (8 clks), starting visible; switch to 01 -> bytes [15:0] blink, no blink reset.
REQ-032 ringing=1 with set_mode=01 and alarm_req=1 -> RING at next frame_end; whole display alternates time_seg / 32'hFFFF_FFFF every 8 clks.
REQ-033 Reset pulse during RING mid-frame -> outputs at REQ-025 values same cycle; first tick 4 clks after release.
